// File: rtl/fila_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fila_pkg
// Description : Shared definitions for the parametrised instruction queue:
//               default geometry, a ceil-log2 helper for pointer and
//               occupancy widths, and the NOP word shown on an empty head.
// Revision    : 1.0 - initial release
// ============================================================================
package fila_pkg;

  localparam int INSTR_W_DEF = 16;
  localparam int DEPTH_DEF   = 16;

  // Word presented on the head output while the queue is empty.
  localparam int unsigned INSTR_NOP = 0;

  // Ceil-log2, used for pointer width (DEPTH) and occupancy width (DEPTH+1).
  function automatic int clog2(input int value);
    int r = 0;
    int v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fila_mem.sv
`default_nettype none
// ============================================================================
// Module      : fila_mem
// Description : DEPTH x INSTR_W register array, one synchronous write port
//               and two asynchronous read ports (head and head+1).
// Ports       : clk            - rising-edge clock for the write port
//               we/waddr/wdata - write enable, address, data
//               raddr0/rdata0  - first asynchronous read port
//               raddr1/rdata1  - second asynchronous read port
// Revision    : 1.0 - initial release
// ============================================================================
module fila_mem #(
  parameter int INSTR_W = 16,
  parameter int DEPTH   = 16,
  parameter int PTR_W   = 4
) (
  input  logic               clk,
  input  logic               we,
  input  logic [PTR_W-1:0]   waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [PTR_W-1:0]   raddr0,
  input  logic [PTR_W-1:0]   raddr1,
  output logic [INSTR_W-1:0] rdata0,
  output logic [INSTR_W-1:0] rdata1
);

  // Storage has no reset: contents are only ever read behind valid pointers.
  logic [INSTR_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata0 = mem_q[raddr0];
  assign rdata1 = mem_q[raddr1];

endmodule
`default_nettype wire

// File: rtl/fila_instrucoes_param.sv
`default_nettype none
// ============================================================================
// Module      : fila_instrucoes_param
// Description : Parametrised show-ahead instruction queue between fetch and
//               dispatch. Push/pop with occupancy count, almost-full flag,
//               synchronous flush and one-cycle rejection pulses.
//               Optional macro FILA_DUAL_POP_EN adds a second pop port
//               (Pop2) with a head+1 output for dual-issue dispatch.
// Ports       : Clock, Reset (async, active-high)
//               Push/Din, Pop, Flush           - control and write data
//               Instrucao_Despachada, Valid    - show-ahead head
//               Full, Empty, Almost_Full, Count - occupancy status
//               Push_Rejeitado, Pop_Rejeitado  - dropped-request pulses
//               Pop2, Instrucao_Despachada2, Valid2 (FILA_DUAL_POP_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
module fila_instrucoes_param
  import fila_pkg::*;
#(
  parameter int INSTR_W  = INSTR_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic                        Push,
  input  logic [INSTR_W-1:0]          Din,
  input  logic                        Pop,
  input  logic                        Flush,
  output logic [INSTR_W-1:0]          Instrucao_Despachada,
  output logic                        Valid,
  output logic                        Full,
  output logic                        Empty,
  output logic                        Almost_Full,
  output logic [clog2(DEPTH+1)-1:0]   Count,
  output logic                        Push_Rejeitado,
  output logic                        Pop_Rejeitado
`ifdef FILA_DUAL_POP_EN
  ,
  input  logic                        Pop2,
  output logic [INSTR_W-1:0]          Instrucao_Despachada2,
  output logic                        Valid2
`endif
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = clog2(DEPTH + 1);

  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push_rej_q, push_rej_d;
  logic               pop_rej_q, pop_rej_d;

  logic               full, empty, two_plus;
  logic               push_ok, pop_ok, pop_rej;
  logic [1:0]         pop_cnt;
  logic [PTR_W-1:0]   rd_addr1;
  logic [INSTR_W-1:0] rd_data0, rd_data1;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign two_plus = (count_q >= CNT_W'(2));
  assign rd_addr1 = rd_ptr_q + PTR_W'(1);

  // A full queue still takes a push when a pop frees the head slot in the
  // same cycle; the pop is always accepted then, since full implies non-empty.
  assign push_ok = Push & (~full | Pop);
  assign pop_ok  = Pop & ~empty;

`ifdef FILA_DUAL_POP_EN
  logic pop2_ok;
  // Second entry leaves only alongside the first and only if it exists.
  assign pop2_ok = Pop & Pop2 & two_plus;
  assign pop_cnt = {1'b0, pop_ok} + {1'b0, pop2_ok};
  assign pop_rej = (Pop & empty) | (Pop2 & ~Pop) | (Pop & Pop2 & ~two_plus);
`else
  assign pop_cnt = {1'b0, pop_ok};
  assign pop_rej = Pop & empty;
`endif

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    push_rej_d = 1'b0;
    pop_rej_d  = 1'b0;
    if (Flush) begin
      // Flush discards everything; concurrent requests are silently dropped.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      rd_ptr_d   = rd_ptr_q + PTR_W'(pop_cnt);
      count_d    = count_q + CNT_W'(push_ok) - CNT_W'(pop_cnt);
      push_rej_d = Push & ~push_ok;
      pop_rej_d  = pop_rej;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      push_rej_q <= 1'b0;
      pop_rej_q  <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      push_rej_q <= push_rej_d;
      pop_rej_q  <= pop_rej_d;
    end
  end

  fila_mem #(
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH),
    .PTR_W   (PTR_W)
  ) u_mem (
    .clk    (Clock),
    .we     (push_ok & ~Flush),
    .waddr  (wr_ptr_q),
    .wdata  (Din),
    .raddr0 (rd_ptr_q),
    .raddr1 (rd_addr1),
    .rdata0 (rd_data0),
    .rdata1 (rd_data1)
  );

  assign Instrucao_Despachada = empty ? INSTR_W'(INSTR_NOP) : rd_data0;
  assign Valid          = ~empty;
  assign Full           = full;
  assign Empty          = empty;
  assign Almost_Full    = (count_q >= CNT_W'(AF_LEVEL));
  assign Count          = count_q;
  assign Push_Rejeitado = push_rej_q;
  assign Pop_Rejeitado  = pop_rej_q;

`ifdef FILA_DUAL_POP_EN
  assign Instrucao_Despachada2 = two_plus ? rd_data1 : INSTR_W'(INSTR_NOP);
  assign Valid2                = two_plus;
`else
  // Second read port only feeds the dual-issue outputs.
  logic unused_rd_data1;
  assign unused_rd_data1 = ^rd_data1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fila_instrucoes_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_fila_instrucoes_param
// Description : Directed self-checking bench for fila_instrucoes_param.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fila_instrucoes_param;

  logic        Clock;
  logic        Reset;
  logic        Push;
  logic [15:0] Din;
  logic        Pop;
  logic        Flush;
  logic [15:0] Instrucao_Despachada;
  logic        Valid;
  logic        Full;
  logic        Empty;
  logic        Almost_Full;
  logic [4:0]  Count;
  logic        Push_Rejeitado;
  logic        Pop_Rejeitado;
`ifdef FILA_DUAL_POP_EN
  logic        Pop2;
  logic [15:0] Instrucao_Despachada2;
  logic        Valid2;
`endif

  int errors = 0;
  int checks = 0;
  logic [15:0] sb[$];

  fila_instrucoes_param #(
    .INSTR_W  (16),
    .DEPTH    (16),
    .AF_LEVEL (14)
  ) dut (
    .Clock                (Clock),
    .Reset                (Reset),
    .Push                 (Push),
    .Din                  (Din),
    .Pop                  (Pop),
    .Flush                (Flush),
    .Instrucao_Despachada (Instrucao_Despachada),
    .Valid                (Valid),
    .Full                 (Full),
    .Empty                (Empty),
    .Almost_Full          (Almost_Full),
    .Count                (Count),
    .Push_Rejeitado       (Push_Rejeitado),
    .Pop_Rejeitado        (Pop_Rejeitado)
`ifdef FILA_DUAL_POP_EN
    ,
    .Pop2                  (Pop2),
    .Instrucao_Despachada2 (Instrucao_Despachada2),
    .Valid2                (Valid2)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Control inputs must never be unknown while out of reset.
  always @(posedge Clock) begin
    if (Reset === 1'b0) begin
      checks++;
      assert (!$isunknown({Push, Pop, Flush}))
      else begin
        errors++;
        $error("FAIL ctrl_x: observed=%b expected=no X", {Push, Pop, Flush});
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, take the edge, release requests 1 ns later.
  task automatic cyc(input logic pu, input logic [15:0] d, input logic po, input logic fl);
    Push  = pu;
    Din   = d;
    Pop   = po;
    Flush = fl;
    @(posedge Clock);
    #1;
    Push  = 1'b0;
    Pop   = 1'b0;
    Flush = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    Push  = 1'b0;
    Din   = '0;
    Pop   = 1'b0;
    Flush = 1'b0;
`ifdef FILA_DUAL_POP_EN
    Pop2  = 1'b0;
`endif
    #12;
    chk("rst_count", Count, 0);
    chk("rst_empty", Empty, 1);
    chk("rst_valid", Valid, 0);
    chk("rst_full",  Full, 0);
    chk("rst_af",    Almost_Full, 0);
    chk("rst_head",  Instrucao_Despachada, 0);
    chk("rst_prej",  Push_Rejeitado, 0);
    chk("rst_orej",  Pop_Rejeitado, 0);
    @(negedge Clock);
    Reset = 1'b0;

    // Basic ordering
    cyc(1, 16'h1111, 0, 0);
    chk("p1_head", Instrucao_Despachada, 16'h1111);
    cyc(1, 16'h2222, 0, 0);
    cyc(1, 16'h3333, 0, 0);
    chk("p3_count", Count, 3);
    chk("p3_head",  Instrucao_Despachada, 16'h1111);
    chk("p3_valid", Valid, 1);
    cyc(0, 0, 1, 0);
    chk("pop1_head", Instrucao_Despachada, 16'h2222);
    chk("pop1_count", Count, 2);
    cyc(0, 0, 1, 0);
    chk("pop2_head", Instrucao_Despachada, 16'h3333);
    cyc(0, 0, 1, 0);
    chk("pop3_empty", Empty, 1);
    chk("pop3_head",  Instrucao_Despachada, 0);
    chk("pop3_count", Count, 0);

    // Pop on empty, then push+pop on empty
    cyc(0, 0, 1, 0);
    chk("epop_rej",   Pop_Rejeitado, 1);
    chk("epop_count", Count, 0);
    cyc(0, 0, 0, 0);
    chk("epop_rej_clr", Pop_Rejeitado, 0);
    cyc(1, 16'hAAAA, 1, 0);
    chk("epp_count", Count, 1);
    chk("epp_head",  Instrucao_Despachada, 16'hAAAA);
    chk("epp_orej",  Pop_Rejeitado, 1);
    chk("epp_prej",  Push_Rejeitado, 0);
    cyc(0, 0, 1, 0);
    chk("epp_drain", Empty, 1);

    // Fill to full, watch almost-full threshold
    for (int i = 0; i < 16; i++) begin
      cyc(1, 16'h0100 + 16'(i), 0, 0);
      chk("fill_af", Almost_Full, (i + 1 >= 14) ? 1 : 0);
    end
    chk("full_flag",  Full, 1);
    chk("full_count", Count, 16);
    chk("full_head",  Instrucao_Despachada, 16'h0100);
    cyc(1, 16'h0BAD, 0, 0);
    chk("fpush_rej",   Push_Rejeitado, 1);
    chk("fpush_count", Count, 16);
    cyc(0, 0, 0, 0);
    chk("fpush_rej_clr", Push_Rejeitado, 0);
    cyc(1, 16'h0BAD, 1, 0);
    chk("fpp_count", Count, 16);
    chk("fpp_head",  Instrucao_Despachada, 16'h0101);
    chk("fpp_prej",  Push_Rejeitado, 0);
    for (int j = 1; j <= 15; j++) begin
      cyc(0, 0, 1, 0);
      chk("fdrain_head", Instrucao_Despachada, (j <= 14) ? 32'h0101 + 32'(j) : 32'h0BAD);
    end
    cyc(0, 0, 1, 0);
    chk("fdrain_empty", Empty, 1);

    // Flush with a concurrent push
    for (int i = 0; i < 10; i++) cyc(1, 16'h0200 + 16'(i), 0, 0);
    chk("pre_flush_count", Count, 10);
    cyc(1, 16'hFFFF, 0, 1);
    chk("flush_count", Count, 0);
    chk("flush_empty", Empty, 1);
    chk("flush_prej",  Push_Rejeitado, 0);
    chk("flush_orej",  Pop_Rejeitado, 0);
    chk("flush_head",  Instrucao_Despachada, 0);
    cyc(1, 16'h1234, 0, 0);
    chk("post_flush_head",  Instrucao_Despachada, 16'h1234);
    chk("post_flush_count", Count, 1);
    cyc(0, 0, 0, 1);

    // Wrap-around at steady occupancy 5, scoreboard ordered
    for (int i = 0; i < 5; i++) begin
      cyc(1, 16'h3000 + 16'(i), 0, 0);
      sb.push_back(16'h3000 + 16'(i));
    end
    for (int i = 5; i < 45; i++) begin
      cyc(1, 16'h3000 + 16'(i), 1, 0);
      sb.push_back(16'h3000 + 16'(i));
      void'(sb.pop_front());
      chk("wrap_head",  Instrucao_Despachada, 32'(sb[0]));
      chk("wrap_count", Count, 5);
    end
    while (sb.size() > 0) begin
      chk("wrap_drain", Instrucao_Despachada, 32'(sb[0]));
      cyc(0, 0, 1, 0);
      void'(sb.pop_front());
    end
    chk("wrap_empty", Empty, 1);

    // Asynchronous reset mid-cycle
    for (int i = 0; i < 7; i++) cyc(1, 16'h4000 + 16'(i), 0, 0);
    chk("pre_arst_count", Count, 7);
    #3;
    Reset = 1'b1;
    #1;
    chk("arst_count", Count, 0);
    chk("arst_empty", Empty, 1);
    chk("arst_head",  Instrucao_Despachada, 0);
    @(negedge Clock);
    Reset = 1'b0;
    cyc(1, 16'h5555, 0, 0);
    chk("post_arst_head",  Instrucao_Despachada, 16'h5555);
    chk("post_arst_count", Count, 1);
    cyc(0, 0, 1, 0);

`ifdef FILA_DUAL_POP_EN
    cyc(1, 16'h7001, 0, 0);
    cyc(1, 16'h7002, 0, 0);
    cyc(1, 16'h7003, 0, 0);
    chk("dual_valid2", Valid2, 1);
    chk("dual_head2",  Instrucao_Despachada2, 16'h7002);
    Pop2 = 1'b1;
    cyc(0, 0, 1, 0);
    Pop2 = 1'b0;
    chk("dual_count", Count, 1);
    chk("dual_head",  Instrucao_Despachada, 16'h7003);
    chk("dual_v2",    Valid2, 0);
    cyc(0, 0, 1, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
